ram_block_mover: RTL and testbench

//  Block-transfer engine on the user-side port of a generated wishbone-gen RAM (e.g. rams_mem1k).
//  One command moves LEN consecutive words between a stream and the RAM:
//   - write: stream -> RAM
//   - read:  RAM -> stream

---
 rtl/ram_block_mover.sv | 174 +++++++++++++++++
 tb/tb_ram_block_mover.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_mover.sv
// ---------------------------------------------------------------------------
// ram_block_mover
// Block-transfer engine for the user port of a generated wishbone-gen RAM.
// One command moves cmd_len_i consecutive words between a stream and the
// RAM, starting at cmd_addr_i. The word address wraps modulo 2^AW.
//   write (cmd_dir_i = 0): sink stream -> RAM
//   read  (cmd_dir_i = 1): RAM -> source stream
//
// Ports
//   clk_i, rst_i            RAM clock, synchronous active-high reset
//   cmd_start_i             start strobe, only looked at while idle
//   cmd_dir_i               0 = write to RAM, 1 = read from RAM
//   cmd_addr_i [AW-1:0]     first word address
//   cmd_len_i  [AW:0]       word count, 0..2^AW
//   cmd_busy_o              high from the cycle after acceptance until done
//   cmd_done_o              one-cycle completion pulse
//   snk_data_i/valid_i/ready_o   write stream (valid/ready handshake)
//   src_data_o/valid_o/ready_i   read stream (valid/ready handshake)
//   ram_addr_o, ram_data_o  RAM word address and write data
//   ram_data_i              RAM read data, valid one cycle after ram_rd_o
//   ram_rd_o, ram_wr_o      RAM read / write strobes (never both high)
//   ram_bwsel_o [DW/8-1:0]  byte enables, always all ones
// ---------------------------------------------------------------------------
module ram_block_mover #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_start_i,
  input  logic              cmd_dir_i,
  input  logic [AW-1:0]     cmd_addr_i,
  input  logic [AW:0]       cmd_len_i,
  output logic              cmd_busy_o,
  output logic              cmd_done_o,
  input  logic [DW-1:0]     snk_data_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DW-1:0]     src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic [AW-1:0]     ram_addr_o,
  output logic [DW-1:0]     ram_data_o,
  input  logic [DW-1:0]     ram_data_i,
  output logic              ram_rd_o,
  output logic              ram_wr_o,
  output logic [DW/8-1:0]   ram_bwsel_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] addr_ptr;
  logic [AW:0]   words_left;
  logic          wr_pending;
  logic [DW-1:0] wr_data;
  logic          inflight;

  logic [DW-1:0] fifo_mem [3];
  logic [1:0]    fifo_wr_ptr;
  logic [1:0]    fifo_rd_ptr;
  logic [1:0]    fifo_count;
  logic [2:0]    credit_used;

  logic          words_remain;
  logic          snk_accept;
  logic          src_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // words_left counts handshakes (write) or issued reads (read), so it
  // reaches zero as soon as the last beat is taken or the last read is issued.
  assign words_remain = (words_left != '0);

  // A read is only issued when the FIFO is guaranteed room for its data,
  // counting the word still in flight but not a pop happening this cycle.
  assign credit_used  = {1'b0, fifo_count} + {2'b00, inflight};

  assign snk_ready_o  = (state == ST_WRITE) && words_remain;
  assign snk_accept   = snk_valid_i && snk_ready_o;
  assign ram_rd_o     = (state == ST_READ) && words_remain && (credit_used < 3'd3);
  assign ram_wr_o     = wr_pending;
  assign ram_addr_o   = addr_ptr;
  assign ram_data_o   = wr_data;
  assign ram_bwsel_o  = '1;

  assign src_valid_o  = (fifo_count != 2'd0);
  assign src_data_o   = fifo_mem[fifo_rd_ptr];
  assign src_pop      = src_valid_o && src_ready_i;

  assign cmd_busy_o   = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
  assign cmd_done_o   = (state == ST_DONE);

  // Next-state logic. A zero-length command of either direction spends one
  // busy cycle in WRITE, where nothing can be accepted, and falls through to
  // DONE. WRITE leaves in the cycle that performs the final RAM write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_start_i) begin
          if (cmd_dir_i && (cmd_len_i != '0)) state_nxt = ST_READ;
          else                                 state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!words_remain) state_nxt = ST_DONE;
      end
      ST_READ: begin
        if (ram_rd_o && (words_left == (AW+1)'(1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && src_pop)))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and datapath. The address pointer advances on each RAM
  // access; since a write strobe follows its handshake by one cycle, a beat
  // accepted in the same cycle as a write still sees the updated pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      addr_ptr    <= '0;
      words_left  <= '0;
      wr_pending  <= 1'b0;
      wr_data     <= '0;
      inflight    <= 1'b0;
      fifo_wr_ptr <= 2'd0;
      fifo_rd_ptr <= 2'd0;
      fifo_count  <= 2'd0;
      for (int i = 0; i < 3; i++) fifo_mem[i] <= '0;
    end else begin
      state <= state_nxt;

      if ((state == ST_IDLE) && cmd_start_i) begin
        addr_ptr   <= cmd_addr_i;
        words_left <= cmd_len_i;
      end else begin
        if (snk_accept || ram_rd_o) words_left <= words_left - (AW+1)'(1);
        if (wr_pending || ram_rd_o) addr_ptr   <= addr_ptr + AW'(1);
      end

      wr_pending <= snk_accept;
      if (snk_accept) wr_data <= snk_data_i;

      inflight <= ram_rd_o;
      if (inflight) begin
        fifo_mem[fifo_wr_ptr] <= ram_data_i;
        fifo_wr_ptr           <= ptr_inc(fifo_wr_ptr);
      end
      if (src_pop) fifo_rd_ptr <= ptr_inc(fifo_rd_ptr);
      fifo_count <= fifo_count + 2'(inflight) - 2'(src_pop);
    end
  end

endmodule

// File: tb/tb_ram_block_mover.sv
// ---------------------------------------------------------------------------
// tb_ram_block_mover
// Self-checking bench for ram_block_mover. A simple 256-word RAM with one
// cycle read latency sits on the RAM port; a reference memory image tracks
// what each command should leave in the RAM and what each read must return.
// ---------------------------------------------------------------------------
module tb_ram_block_mover;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef logic [DW-1:0] word_q_t [$];

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cmd_start_i;
  logic              cmd_dir_i;
  logic [AW-1:0]     cmd_addr_i;
  logic [AW:0]       cmd_len_i;
  logic              cmd_busy_o;
  logic              cmd_done_o;
  logic [DW-1:0]     snk_data_i;
  logic              snk_valid_i;
  logic              snk_ready_o;
  logic [DW-1:0]     src_data_o;
  logic              src_valid_o;
  logic              src_ready_i;
  logic [AW-1:0]     ram_addr_o;
  logic [DW-1:0]     ram_data_o;
  logic [DW-1:0]     ram_data_i;
  logic              ram_rd_o;
  logic              ram_wr_o;
  logic [DW/8-1:0]   ram_bwsel_o;

  always #5 clk_i = ~clk_i;

  ram_block_mover #(.DW(DW), .AW(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_start_i (cmd_start_i),
    .cmd_dir_i   (cmd_dir_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_busy_o  (cmd_busy_o),
    .cmd_done_o  (cmd_done_o),
    .snk_data_i  (snk_data_i),
    .snk_valid_i (snk_valid_i),
    .snk_ready_o (snk_ready_o),
    .src_data_o  (src_data_o),
    .src_valid_o (src_valid_o),
    .src_ready_i (src_ready_i),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (ram_data_i),
    .ram_rd_o    (ram_rd_o),
    .ram_wr_o    (ram_wr_o),
    .ram_bwsel_o (ram_bwsel_o)
  );

  // Behavioural RAM on the user port: write on the strobe, read data one
  // cycle after the read strobe.
  logic [DW-1:0] tb_mem [DEPTH];
  always @(posedge clk_i) begin
    if (ram_wr_o) tb_mem[ram_addr_o] <= ram_data_o;
    if (ram_rd_o) ram_data_i <= tb_mem[ram_addr_o];
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Reference image of the RAM contents implied by the commands issued.
  logic [DW-1:0] exp_mem [DEPTH];

  // Per-command observation logs, filled on each falling edge.
  logic [AW-1:0] log_wr_addr [$];
  logic [DW-1:0] log_wr_data [$];
  int            log_wr_cyc  [$];
  logic [AW-1:0] log_rd_addr [$];
  int            log_rd_cyc  [$];
  logic [DW-1:0] log_pop     [$];
  int            log_start_cyc;
  int            log_done_cyc;
  int            log_first_valid;
  bit            log_busy_next;
  bit            log_overlap;
  bit            log_bwsel_bad;
  bit            log_ready_late;
  bit            log_timeout;

  task automatic clear_logs();
    log_wr_addr.delete();
    log_wr_data.delete();
    log_wr_cyc.delete();
    log_rd_addr.delete();
    log_rd_cyc.delete();
    log_pop.delete();
    log_done_cyc    = -1;
    log_first_valid = -1;
    log_busy_next   = 1'b0;
    log_overlap     = 1'b0;
    log_bwsel_bad   = 1'b0;
    log_ready_late  = 1'b0;
    log_timeout     = 1'b0;
  endtask

  task automatic observe();
    if (ram_wr_o) begin
      log_wr_addr.push_back(ram_addr_o);
      log_wr_data.push_back(ram_data_o);
      log_wr_cyc.push_back(cyc);
      if (ram_bwsel_o !== '1) log_bwsel_bad = 1'b1;
    end
    if (ram_rd_o) begin
      log_rd_addr.push_back(ram_addr_o);
      log_rd_cyc.push_back(cyc);
    end
    if (ram_rd_o && ram_wr_o) log_overlap = 1'b1;
    if (cmd_done_o && log_done_cyc < 0) log_done_cyc = cyc;
    if (src_valid_o && log_first_valid < 0) log_first_valid = cyc;
  endtask

  // Runs one write command; the stream has gaps with probability gap_pct.
  task automatic do_write(input int addr, input int len, input int gap_pct, input word_q_t data_q);
    int  idx;
    bit  done;
    clear_logs();
    idx  = 0;
    done = 1'b0;
    @(negedge clk_i);
    cmd_start_i   = 1'b1;
    cmd_dir_i     = 1'b0;
    cmd_addr_i    = AW'(addr);
    cmd_len_i     = (AW+1)'(len);
    log_start_cyc = cyc;
    for (int n = 0; n < len * 4 + 30; n++) begin
      @(negedge clk_i);
      cmd_start_i = 1'b0;
      observe();
      if (n == 0) log_busy_next = cmd_busy_o;
      if (idx == len && snk_ready_o) log_ready_late = 1'b1;
      if (cmd_done_o) begin
        done = 1'b1;
        break;
      end
      if (idx < len && $urandom_range(99) >= gap_pct) begin
        snk_valid_i = 1'b1;
        snk_data_i  = data_q[idx];
      end else begin
        snk_valid_i = 1'b0;
        snk_data_i  = $urandom;
      end
      if (snk_valid_i && snk_ready_o) idx++;
    end
    snk_valid_i = 1'b0;
    log_timeout = !done;
    for (int i = 0; i < len; i++) exp_mem[(addr + i) % DEPTH] = data_q[i];
  endtask

  // Runs one read command. mode 0: ready always high, 1: ready 1,0,0,...,
  // 2: random ready. abort_after > 0 returns once that many words popped.
  task automatic do_read(input int addr, input int len, input int mode, input int abort_after);
    bit done;
    clear_logs();
    done = 1'b0;
    @(negedge clk_i);
    cmd_start_i   = 1'b1;
    cmd_dir_i     = 1'b1;
    cmd_addr_i    = AW'(addr);
    cmd_len_i     = (AW+1)'(len);
    log_start_cyc = cyc;
    for (int n = 0; n < len * 6 + 30; n++) begin
      @(negedge clk_i);
      cmd_start_i = 1'b0;
      observe();
      if (n == 0) log_busy_next = cmd_busy_o;
      if (cmd_done_o) begin
        done = 1'b1;
        break;
      end
      if (abort_after > 0 && log_pop.size() == abort_after) begin
        done = 1'b1;
        break;
      end
      case (mode)
        0:       src_ready_i = 1'b1;
        1:       src_ready_i = (n % 3 == 0);
        default: src_ready_i = 1'($urandom_range(1));
      endcase
      if (src_valid_o && src_ready_i) log_pop.push_back(src_data_o);
    end
    src_ready_i = 1'b0;
    log_timeout = !done;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    cmd_start_i = 1'b1;
    cmd_dir_i   = 1'b0;
    cmd_addr_i  = 8'h12;
    cmd_len_i   = 9'd5;
    snk_valid_i = 1'b1;
    snk_data_i  = 32'h1234_5678;
    src_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (cmd_busy_o !== 1'b0)  begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", cmd_busy_o); end
    checks++; if (cmd_done_o !== 1'b0)  begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", cmd_done_o); end
    checks++; if (snk_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_snk_ready got=%b exp=0", snk_ready_o); end
    checks++; if (src_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_src_valid got=%b exp=0", src_valid_o); end
    checks++; if (ram_rd_o !== 1'b0)    begin failures++; $display("[TB] FAIL reset_ram_rd got=%b exp=0", ram_rd_o); end
    checks++; if (ram_wr_o !== 1'b0)    begin failures++; $display("[TB] FAIL reset_ram_wr got=%b exp=0", ram_wr_o); end
    checks++; if (ram_addr_o !== '0)    begin failures++; $display("[TB] FAIL reset_ram_addr got=%0h exp=0", ram_addr_o); end
    checks++; if (ram_data_o !== '0)    begin failures++; $display("[TB] FAIL reset_ram_data got=%0h exp=0", ram_data_o); end
    checks++; if (ram_bwsel_o !== 4'hF) begin failures++; $display("[TB] FAIL reset_bwsel got=%0h exp=f", ram_bwsel_o); end
    rst_i       = 1'b0;
    cmd_start_i = 1'b0;
    snk_valid_i = 1'b0;
  endtask

  task automatic test_write_basic();
    word_q_t d;
    d = '{32'hdeadbeef, 32'hcafecafe, 32'hfacedead, 32'h55555555};
    do_write(0, 4, 0, d);
    checks++; if (log_timeout !== 1'b0) begin failures++; $display("[TB] FAIL wr_basic_done_seen got=timeout exp=done"); end
    checks++; if (log_busy_next !== 1'b1) begin failures++; $display("[TB] FAIL wr_basic_busy got=%b exp=1", log_busy_next); end
    checks++; if (log_wr_addr.size() !== 4) begin failures++; $display("[TB] FAIL wr_basic_count got=%0d exp=4", log_wr_addr.size()); end
    for (int i = 0; i < 4 && i < log_wr_addr.size(); i++) begin
      checks++; if (log_wr_addr[i] !== AW'(i)) begin failures++; $display("[TB] FAIL wr_basic_addr[%0d] got=%0h exp=%0h", i, log_wr_addr[i], i); end
      checks++; if (log_wr_data[i] !== d[i]) begin failures++; $display("[TB] FAIL wr_basic_data[%0d] got=%0h exp=%0h", i, log_wr_data[i], d[i]); end
      checks++; if (log_wr_cyc[i] !== log_start_cyc + 2 + i) begin failures++; $display("[TB] FAIL wr_basic_cycle[%0d] got=%0d exp=%0d", i, log_wr_cyc[i], log_start_cyc + 2 + i); end
    end
    if (log_wr_cyc.size() == 4) begin
      checks++; if (log_done_cyc !== log_wr_cyc[3] + 1) begin failures++; $display("[TB] FAIL wr_basic_done_cycle got=%0d exp=%0d", log_done_cyc, log_wr_cyc[3] + 1); end
    end
    checks++; if (log_bwsel_bad !== 1'b0) begin failures++; $display("[TB] FAIL wr_basic_bwsel got=not_all_ones exp=all_ones"); end
    checks++; if (log_ready_late !== 1'b0) begin failures++; $display("[TB] FAIL wr_basic_ready_after_last got=1 exp=0"); end
  endtask

  task automatic test_full_read();
    word_q_t d;
    int      bad;
    int      bad_idx;
    for (int i = 0; i < DEPTH; i++) d.push_back(DW'(257 - i));
    do_write(0, DEPTH, 0, d);
    checks++; if (log_wr_addr.size() !== DEPTH) begin failures++; $display("[TB] FAIL preload_count got=%0d exp=%0d", log_wr_addr.size(), DEPTH); end
    bad = 0; bad_idx = -1;
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== DW'(257 - i)) begin if (bad == 0) bad_idx = i; bad++; end
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL preload_contents got=%0d_bad_words(first %0d) exp=0", bad, bad_idx); end

    do_read(0, DEPTH, 0, 0);
    checks++; if (log_timeout !== 1'b0) begin failures++; $display("[TB] FAIL full_read_done_seen got=timeout exp=done"); end
    checks++; if (log_pop.size() !== DEPTH) begin failures++; $display("[TB] FAIL full_read_count got=%0d exp=%0d", log_pop.size(), DEPTH); end
    bad = 0; bad_idx = -1;
    for (int i = 0; i < DEPTH && i < log_pop.size(); i++) if (log_pop[i] !== DW'(257 - i)) begin if (bad == 0) bad_idx = i; bad++; end
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL full_read_data got=%0d_bad_words(first %0d) exp=0", bad, bad_idx); end
    checks++; if (log_rd_cyc.size() !== DEPTH) begin failures++; $display("[TB] FAIL full_read_strobes got=%0d exp=%0d", log_rd_cyc.size(), DEPTH); end
    if (log_rd_cyc.size() == DEPTH) begin
      checks++; if (log_rd_cyc[DEPTH-1] - log_rd_cyc[0] !== DEPTH - 1) begin failures++; $display("[TB] FAIL full_read_continuous got=%0d exp=%0d", log_rd_cyc[DEPTH-1] - log_rd_cyc[0], DEPTH - 1); end
      checks++; if (log_first_valid - log_rd_cyc[0] !== 2) begin failures++; $display("[TB] FAIL full_read_latency got=%0d exp=2", log_first_valid - log_rd_cyc[0]); end
    end
    checks++; if (log_overlap !== 1'b0) begin failures++; $display("[TB] FAIL full_read_rd_wr_overlap got=1 exp=0"); end
  endtask

  task automatic test_wrap();
    word_q_t d;
    for (int i = 0; i < 4; i++) d.push_back($urandom);
    do_write(8'hFE, 4, 30, d);
    checks++; if (log_wr_addr.size() !== 4) begin failures++; $display("[TB] FAIL wrap_wr_count got=%0d exp=4", log_wr_addr.size()); end
    for (int i = 0; i < 4 && i < log_wr_addr.size(); i++) begin
      checks++; if (log_wr_addr[i] !== AW'((8'hFE + i) % DEPTH)) begin failures++; $display("[TB] FAIL wrap_wr_addr[%0d] got=%0h exp=%0h", i, log_wr_addr[i], (8'hFE + i) % DEPTH); end
    end
    do_read(8'hFE, 4, 2, 0);
    checks++; if (log_pop.size() !== 4) begin failures++; $display("[TB] FAIL wrap_rd_count got=%0d exp=4", log_pop.size()); end
    for (int i = 0; i < 4 && i < log_pop.size(); i++) begin
      checks++; if (log_pop[i] !== d[i]) begin failures++; $display("[TB] FAIL wrap_rd_data[%0d] got=%0h exp=%0h", i, log_pop[i], d[i]); end
      checks++; if (log_rd_addr[i] !== AW'((8'hFE + i) % DEPTH)) begin failures++; $display("[TB] FAIL wrap_rd_addr[%0d] got=%0h exp=%0h", i, log_rd_addr[i], (8'hFE + i) % DEPTH); end
    end
  endtask

  task automatic test_backpressure();
    word_q_t d;
    int      addr;
    addr = $urandom_range(DEPTH - 1);
    for (int i = 0; i < 8; i++) d.push_back($urandom);
    do_write(addr, 8, 0, d);
    for (int mode = 1; mode <= 2; mode++) begin
      do_read(addr, 8, mode, 0);
      checks++; if (log_timeout !== 1'b0) begin failures++; $display("[TB] FAIL bp_done_seen mode=%0d got=timeout exp=done", mode); end
      checks++; if (log_pop.size() !== 8) begin failures++; $display("[TB] FAIL bp_count mode=%0d got=%0d exp=8", mode, log_pop.size()); end
      for (int i = 0; i < 8 && i < log_pop.size(); i++) begin
        checks++; if (log_pop[i] !== exp_mem[(addr + i) % DEPTH]) begin failures++; $display("[TB] FAIL bp_data[%0d] mode=%0d got=%0h exp=%0h", i, mode, log_pop[i], exp_mem[(addr + i) % DEPTH]); end
      end
      checks++; if (log_rd_cyc.size() !== 8) begin failures++; $display("[TB] FAIL bp_strobes mode=%0d got=%0d exp=8", mode, log_rd_cyc.size()); end
    end
  endtask

  task automatic test_zero_len();
    bit busy_later;
    for (int dir = 0; dir < 2; dir++) begin
      clear_logs();
      busy_later = 1'b0;
      @(negedge clk_i);
      cmd_start_i = 1'b1;
      cmd_dir_i   = 1'(dir);
      cmd_addr_i  = 8'h33;
      cmd_len_i   = '0;
      @(negedge clk_i);
      observe();
      checks++; if (cmd_busy_o !== 1'b1) begin failures++; $display("[TB] FAIL zero_len_busy dir=%0d got=%b exp=1", dir, cmd_busy_o); end
      checks++; if (snk_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL zero_len_ready dir=%0d got=%b exp=0", dir, snk_ready_o); end
      cmd_dir_i  = 1'b0;
      cmd_addr_i = 8'h40;
      cmd_len_i  = 9'd5;
      @(negedge clk_i);
      observe();
      cmd_start_i = 1'b0;
      checks++; if (cmd_done_o !== 1'b1) begin failures++; $display("[TB] FAIL zero_len_done dir=%0d got=%b exp=1", dir, cmd_done_o); end
      checks++; if (cmd_busy_o !== 1'b0) begin failures++; $display("[TB] FAIL zero_len_busy_in_done dir=%0d got=%b exp=0", dir, cmd_busy_o); end
      repeat (3) begin
        @(negedge clk_i);
        observe();
        if (cmd_busy_o || snk_ready_o) busy_later = 1'b1;
      end
      checks++; if (busy_later !== 1'b0) begin failures++; $display("[TB] FAIL ignored_start dir=%0d got=accepted exp=ignored", dir); end
      checks++; if (log_wr_cyc.size() + log_rd_cyc.size() !== 0) begin failures++; $display("[TB] FAIL zero_len_strobes dir=%0d got=%0d exp=0", dir, log_wr_cyc.size() + log_rd_cyc.size()); end
    end
  endtask

  task automatic test_back_to_back();
    word_q_t d;
    int      addr;
    int      len;
    int      prev_done;
    addr = $urandom_range(DEPTH - 1);
    len  = $urandom_range(12, 3);
    for (int i = 0; i < len; i++) d.push_back($urandom);
    do_write(addr, len, 20, d);
    prev_done = log_done_cyc;
    do_read(addr, len, 0, 0);
    checks++; if (log_start_cyc !== prev_done + 1) begin failures++; $display("[TB] FAIL b2b_start_cycle got=%0d exp=%0d", log_start_cyc, prev_done + 1); end
    checks++; if (log_busy_next !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy got=%b exp=1", log_busy_next); end
    checks++; if (log_pop.size() !== len) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", log_pop.size(), len); end
    for (int i = 0; i < len && i < log_pop.size(); i++) begin
      checks++; if (log_pop[i] !== d[i]) begin failures++; $display("[TB] FAIL b2b_data[%0d] got=%0h exp=%0h", i, log_pop[i], d[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    do_read(0, 8, 0, 3);
    checks++; if (log_pop.size() !== 3) begin failures++; $display("[TB] FAIL abort_pops got=%0d exp=3", log_pop.size()); end
    for (int i = 0; i < 3 && i < log_pop.size(); i++) begin
      checks++; if (log_pop[i] !== exp_mem[i]) begin failures++; $display("[TB] FAIL abort_data[%0d] got=%0h exp=%0h", i, log_pop[i], exp_mem[i]); end
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (ram_rd_o !== 1'b0)    begin failures++; $display("[TB] FAIL abort_ram_rd got=%b exp=0", ram_rd_o); end
    checks++; if (ram_wr_o !== 1'b0)    begin failures++; $display("[TB] FAIL abort_ram_wr got=%b exp=0", ram_wr_o); end
    checks++; if (src_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_src_valid got=%b exp=0", src_valid_o); end
    checks++; if (cmd_busy_o !== 1'b0)  begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", cmd_busy_o); end
    rst_i = 1'b0;
    do_read(0, 8, 2, 0);
    checks++; if (log_pop.size() !== 8) begin failures++; $display("[TB] FAIL after_abort_count got=%0d exp=8", log_pop.size()); end
    for (int i = 0; i < 8 && i < log_pop.size(); i++) begin
      checks++; if (log_pop[i] !== exp_mem[i]) begin failures++; $display("[TB] FAIL after_abort_data[%0d] got=%0h exp=%0h", i, log_pop[i], exp_mem[i]); end
    end
  endtask

  task automatic test_random();
    word_q_t d;
    int      addr;
    int      len;
    int      bad;
    for (int it = 0; it < 4; it++) begin
      d.delete();
      addr = $urandom_range(DEPTH - 1);
      len  = $urandom_range(40, 1);
      for (int i = 0; i < len; i++) d.push_back($urandom);
      do_write(addr, len, 40, d);
      checks++; if (log_wr_addr.size() !== len) begin failures++; $display("[TB] FAIL rand_wr_count it=%0d got=%0d exp=%0d", it, log_wr_addr.size(), len); end
      do_read(addr, len, 2, 0);
      checks++; if (log_pop.size() !== len) begin failures++; $display("[TB] FAIL rand_rd_count it=%0d got=%0d exp=%0d", it, log_pop.size(), len); end
      bad = 0;
      for (int i = 0; i < len && i < log_pop.size(); i++) if (log_pop[i] !== exp_mem[(addr + i) % DEPTH]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL rand_rd_data it=%0d got=%0d_bad_words exp=0", it, bad); end
      checks++; if (log_overlap !== 1'b0) begin failures++; $display("[TB] FAIL rand_rd_wr_overlap it=%0d got=1 exp=0", it); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_full_read();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
